// File: rtl/mem_arbiter_fsm_if.sv
// Bundle of the fetch port, data port and single-ported RAM signals around the arbiter.
// Latency: none, wiring only.
// Backpressure: none here; stalls are carried by iwait/dwait and the ramstate handshake.
//
// Port summary:
//   fetch  : iREN, iaddr -> iload, iwait
//   data   : dREN, dWEN, daddr, dstore -> dload, dwait
//   RAM    : ramstate, ramload -> ramREN, ramWEN, ramaddr, ramstore
//   status : ram_fault
//   slave  = arbiter side, master = CPU/RAM environment side
interface mem_arbiter_fsm_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [1:0]  ramstate;
  logic [31:0] ramload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        iwait;
  logic        dwait;
  logic        ram_fault;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output ramREN, ramWEN, ramaddr, ramstore, iload, dload, iwait, dwait, ram_fault
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    input  ramREN, ramWEN, ramaddr, ramstore, iload, dload, iwait, dwait, ram_fault
  );
endinterface

// File: rtl/mem_arbiter_fsm.sv
// Registered arbiter sharing one single-ported RAM between instruction fetch and data access.
// Latency: request seen in IDLE cycle N is granted in cycle N+1; earliest completion is N+1.
// Backpressure: requesters stall on iwait/dwait until RAM reports ACCESS for their grant.
//
// Ports: CLK (rising edge), RST (synchronous, active-high), bus (mem_arbiter_fsm_if.slave).
// Data wins ties unless DSTREAK_MAX data completions have run back to back, then fetch goes.
// ERROR responses are retried by re-arbitration; MAX_RETRY errors on one access set ram_fault.
module mem_arbiter_fsm #(
  parameter int unsigned DSTREAK_MAX = 4,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic              CLK,
  input  logic              RST,
  mem_arbiter_fsm_if.slave  bus
);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [3:0] DS_MAX    = 4'(DSTREAK_MAX);
  localparam logic [2:0] MR_MAX    = 3'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] dstreak_q, dstreak_d;
  logic [2:0] retry_q, retry_d;
  logic       fault_q, fault_d;

  logic       dreq;
  logic       access;
  logic       error;
  logic [2:0] retry_inc;
  logic [2:0] err_retry;
  logic       err_fault;

  assign dreq   = bus.dREN | bus.dWEN;
  assign access = (bus.ramstate == RS_ACCESS);
  assign error  = (bus.ramstate == RS_ERROR);

  // Outcome of one more ERROR on the current access: hitting the limit
  // raises the sticky fault and starts the count over for the next access.
  assign retry_inc = retry_q + 3'd1;
  assign err_retry = (retry_inc == MR_MAX) ? 3'd0 : retry_inc;
  assign err_fault = (retry_inc == MR_MAX) ? 1'b1 : fault_q;

  // Read data is shared; each requester only trusts it while its wait is low.
  assign bus.iload     = bus.ramload;
  assign bus.dload     = bus.ramload;
  assign bus.ram_fault = fault_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      dstreak_q <= 4'd0;
      retry_q   <= 3'd0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      retry_q   <= retry_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dstreak_d    = dstreak_q;
    retry_d      = retry_q;
    fault_d      = fault_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'd0;
    bus.ramstore = 32'd0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;

    unique case (state_q)
      IDLE: begin
        // Data takes ties until its streak hits the limit.
        if (dreq && (!bus.iREN || (dstreak_q < DS_MAX))) begin
          state_d = DATA;
        end else if (bus.iREN) begin
          state_d = INST;
        end
      end

      INST: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        bus.iwait   = ~access;
        if (access) begin
          state_d   = IDLE;
          retry_d   = 3'd0;
          dstreak_d = 4'd0;
        end else if (!bus.iREN) begin
          // Requester gave up; an ERROR in the same cycle is not counted.
          state_d = IDLE;
        end else if (error) begin
          state_d = IDLE;
          retry_d = err_retry;
          fault_d = err_fault;
        end
      end

      DATA: begin
        bus.ramaddr = bus.daddr;
        // A store wins when the CPU asserts both enables.
        if (bus.dWEN) begin
          bus.ramWEN   = 1'b1;
          bus.ramstore = bus.dstore;
        end else begin
          bus.ramREN = 1'b1;
        end
        bus.dwait = ~access;
        if (access) begin
          state_d   = IDLE;
          retry_d   = 3'd0;
          dstreak_d = (dstreak_q < DS_MAX) ? dstreak_q + 4'd1 : dstreak_q;
        end else if (!dreq) begin
          state_d = IDLE;
        end else if (error) begin
          state_d = IDLE;
          retry_d = err_retry;
          fault_d = err_fault;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
module tb_mem_arbiter_fsm;

  localparam int DSMAX = 4;
  localparam int MRMAX = 3;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_arbiter_fsm_if bus ();

  mem_arbiter_fsm #(.DSTREAK_MAX(DSMAX), .MAX_RETRY(MRMAX)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic        iw;
    logic        dw;
    logic        fault;
    logic [31:0] load;
  } exp_t;

  typedef struct {
    byte         port;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
  } comp_t;

  exp_t  exp_q[$];
  comp_t log_q[$];
  int    n_checks = 0;
  int    n_err    = 0;
  int    wen_cycles = 0;
  int    ren_cycles = 0;

  // Reference model: who currently holds the RAM (0 nobody, 1 fetch, 2 data),
  // how many data transfers have completed since fetch last completed,
  // and how many errors the current access has absorbed.
  int m_owner  = 0;
  int m_streak = 0;
  int m_retry  = 0;
  bit m_fault  = 0;
  bit m_known  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the queued prediction.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ramREN",    32'(bus.ramREN),    32'(e.ren));
      chk("ramWEN",    32'(bus.ramWEN),    32'(e.wen));
      chk("ramaddr",   bus.ramaddr,        e.addr);
      chk("ramstore",  bus.ramstore,       e.store);
      chk("iwait",     32'(bus.iwait),     32'(e.iw));
      chk("dwait",     32'(bus.dwait),     32'(e.dw));
      chk("ram_fault", 32'(bus.ram_fault), 32'(e.fault));
      chk("iload",     bus.iload,          e.load);
      chk("dload",     bus.dload,          e.load);
    end
    if (bus.ramWEN === 1'b1) wen_cycles++;
    if (bus.ramREN === 1'b1) ren_cycles++;
    if (bus.iwait === 1'b0) log_q.push_back('{8'h49, bus.ramaddr, bus.iload, 1'b0});
    if (bus.dwait === 1'b0)
      log_q.push_back('{8'h44, bus.ramaddr, bus.ramWEN ? bus.ramstore : bus.dload, bus.ramWEN});
  end

  // Drive one cycle, predict its outputs, then advance the model across the edge.
  task automatic step(input logic rst, input logic ir, input logic dr, input logic dw,
                      input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                      input logic [1:0] rs, input logic [31:0] rl);
    exp_t e;
    bit   dreq;
    RST = rst;
    bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw;
    bus.iaddr = ia; bus.daddr = da; bus.dstore = ds;
    bus.ramstate = rs; bus.ramload = rl;
    dreq = dr | dw;

    e = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, m_fault, rl};
    if (m_owner == 1) begin
      e.ren = 1'b1; e.addr = ia; e.iw = (rs != ACCESS);
    end else if (m_owner == 2) begin
      e.addr = da;
      if (dw) begin e.wen = 1'b1; e.store = ds; end
      else e.ren = 1'b1;
      e.dw = (rs != ACCESS);
    end
    if (m_known) exp_q.push_back(e);

    @(posedge CLK);
    if (rst) begin
      m_owner = 0; m_streak = 0; m_retry = 0; m_fault = 0; m_known = 1;
    end else if (m_owner == 0) begin
      if (dreq && ir) m_owner = (m_streak < DSMAX) ? 2 : 1;
      else if (dreq)  m_owner = 2;
      else if (ir)    m_owner = 1;
    end else begin
      bit still = (m_owner == 1) ? ir : dreq;
      if (rs == ACCESS) begin
        if (m_owner == 1) m_streak = 0;
        else if (m_streak < DSMAX) m_streak++;
        m_retry = 0;
        m_owner = 0;
      end else if (!still) begin
        m_owner = 0;
      end else if (rs == ERROR) begin
        m_owner = 0;
        m_retry++;
        if (m_retry == MRMAX) begin m_fault = 1; m_retry = 0; end
      end
    end
    #1;
  endtask

  task automatic idle(input logic [1:0] rs);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, rs, 32'h0);
  endtask

  task automatic reset1();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, FREE, 32'h0);
  endtask

  initial begin
    string order;
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; bus.iaddr = 0; bus.daddr = 0;
    bus.dstore = 0; bus.ramstate = FREE; bus.ramload = 0;
    @(posedge CLK); #1;

    // Reset held two cycles with both requesters active.
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h8, 32'h0, ACCESS, 32'h1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h8, 32'h0, ACCESS, 32'h1);
    chk("fault_after_reset", 32'(bus.ram_fault), 32'd0);
    chk("ren_after_reset", 32'(bus.ramREN), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE, 32'h0);
    reset1();

    // Single fetch.
    log_q.delete();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, ACCESS, 32'h8C010004);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, ACCESS, 32'h8C010004);
    idle(FREE);
    chk("fetch_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) begin
      chk("fetch_port", 32'(log_q[0].port), 32'h49);
      chk("fetch_addr", log_q[0].addr, 32'h40);
      chk("fetch_data", log_q[0].data, 32'h8C010004);
    end

    // Store with both enables: BUSY three cycles then ACCESS.
    log_q.delete(); wen_cycles = 0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF, BUSY, 32'h0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF, BUSY, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF, ACCESS, 32'h0);
    idle(FREE);
    chk("store_wen_cycles", 32'(wen_cycles), 32'd4);
    chk("store_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) begin
      chk("store_we", 32'(log_q[0].we), 32'd1);
      chk("store_addr", log_q[0].addr, 32'h100);
      chk("store_data", log_q[0].data, 32'hDEADBEEF);
    end

    // Fairness with both ports saturating the RAM.
    reset1();
    log_q.delete();
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(i), 32'h300 + 32'(i), 32'h0, ACCESS, 32'(i));
    idle(FREE);
    chk("fair_count", 32'(log_q.size()), 32'd10);
    order = "DDDDIDDDDI";
    for (int i = 0; i < 10 && i < log_q.size(); i++)
      chk($sformatf("fair_grant%0d", i), 32'(log_q[i].port), 32'(order[i]));

    // Repeated ERROR on a fetch until the fault trips.
    reset1();
    log_q.delete(); ren_cycles = 0;
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0, ERROR, 32'h0);
    chk("fault_before_third", 32'(bus.ram_fault), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0, ERROR, 32'h0);
    chk("fault_after_third", 32'(bus.ram_fault), 32'd1);
    chk("err_grants", 32'(ren_cycles), 32'd3);
    chk("err_no_completion", 32'(log_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) idle(ACCESS);
    chk("fault_sticky", 32'(bus.ram_fault), 32'd1);
    reset1();
    chk("fault_cleared", 32'(bus.ram_fault), 32'd0);

    // Abort a BUSY data access, pending fetch takes over.
    log_q.delete();
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h600, 32'h0, BUSY, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h600, 32'h0, BUSY, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h700, 32'h600, 32'h0, BUSY, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h700, 32'h600, 32'h0, BUSY, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h700, 32'h600, 32'h0, ACCESS, 32'h77);
    idle(FREE);
    chk("abort_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) chk("abort_port", 32'(log_q[0].port), 32'h49);

    // Randomized traffic, occasional resets.
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] rs;
      int r;
      r = $urandom_range(0, 99);
      rs = (r < 40) ? ACCESS : (r < 70) ? BUSY : (r < 85) ? FREE : ERROR;
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
           $urandom, $urandom, $urandom, rs, $urandom);
    end
    idle(FREE);
    @(negedge CLK); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
